// File: rtl/riscv_pkg.sv
// Shared types for the atomic memory operation unit.
//   amo_op_e      : AMO operation encoding carried on i_amo_op
//   amo_state_e   : sequencing states of amo_unit
//   reservation_t : LR/SC reservation {valid, word address}
package riscv_pkg;

  localparam int XLEN_P = 32;

  typedef enum logic [3:0] {
    AMO_SWAP = 4'd0,
    AMO_ADD  = 4'd1,
    AMO_XOR  = 4'd2,
    AMO_AND  = 4'd3,
    AMO_OR   = 4'd4,
    AMO_MIN  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MINU = 4'd7,
    AMO_MAXU = 4'd8
  } amo_op_e;

  typedef enum logic [1:0] {
    AMO_IDLE  = 2'd0,
    AMO_READ  = 2'd1,
    AMO_WRITE = 2'd2,
    AMO_HOLD  = 2'd3
  } amo_state_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN_P-3:0] word_addr;
  } reservation_t;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO datapath: new memory value from (op, old, rs2).
// Ports: op (amo_op_e), old_val (memory value), rs2 (operand), new_val.
// Macro FROST_AMO_MINMAX_EN builds the MIN/MAX/MINU/MAXU comparators; when
// undefined those encodings return old_val so memory is left unchanged.
module amo_alu import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  amo_op_e         op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] new_val
);

`ifdef FROST_AMO_MINMAX_EN
  logic lt_s, lt_u;
  assign lt_s = $signed(old_val) < $signed(rs2);
  assign lt_u = old_val < rs2;
`endif

  always_comb begin
    new_val = old_val;
    case (op)
      AMO_SWAP: new_val = rs2;
      AMO_ADD:  new_val = old_val + rs2;
      AMO_XOR:  new_val = old_val ^ rs2;
      AMO_AND:  new_val = old_val & rs2;
      AMO_OR:   new_val = old_val | rs2;
`ifdef FROST_AMO_MINMAX_EN
      AMO_MIN:  new_val = lt_s ? old_val : rs2;
      AMO_MAX:  new_val = lt_s ? rs2 : old_val;
      AMO_MINU: new_val = lt_u ? old_val : rs2;
      AMO_MAXU: new_val = lt_u ? rs2 : old_val;
`endif
      default:  new_val = old_val;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// RV32A atomic unit: runs AMO read-modify-write sequences on the data memory
// port and tracks the LR/SC reservation.
// Inputs : i_clk, i_reset (async, active high), i_stall_other, i_flush,
//          EX->MA fields (i_is_amo, i_amo_op, i_is_lr, i_is_sc, i_address,
//          i_rs2_data), BRAM read data, regular-store snoop.
// Outputs: o_stall_for_amo, memory override (address/data/byte enables),
//          o_amo_result (registered old value) with o_amo_write_enable pulse,
//          o_sc_success (combinational).
// Macro FROST_AMO_MINMAX_EN enables MIN/MAX/MINU/MAXU in amo_alu.
module amo_unit import riscv_pkg::*; #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000,
  parameter logic [XLEN-1:0] MMIO_SIZE_BYTES = 32'h28
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall_other,
  input  logic            i_flush,
  input  logic            i_is_amo,
  input  amo_op_e         i_amo_op,
  input  logic            i_is_lr,
  input  logic            i_is_sc,
  input  logic [XLEN-1:0] i_address,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_data_mem_rd_data,
  input  logic            i_store_snoop_valid,
  input  logic [XLEN-1:0] i_store_snoop_addr,
  output logic            o_stall_for_amo,
  output logic            o_mem_addr_override,
  output logic [XLEN-1:0] o_mem_address,
  output logic [XLEN-1:0] o_mem_write_data,
  output logic [3:0]      o_mem_byte_write_enable,
  output logic [XLEN-1:0] o_amo_result,
  output logic            o_amo_write_enable,
  output logic            o_sc_success
);

  amo_state_e      state, state_nxt;
  amo_op_e         op_r;
  logic [XLEN-1:0] addr_r, rs2_r, new_val;
  reservation_t    rsv;
  logic            done;   // AMO just retired; EX->MA still shows it this cycle
  logic            start, adv, in_mmio, snoop_hit, amo_hit;
  logic            unused_bits;

  assign unused_bits = ^{i_store_snoop_addr[1:0], addr_r[1:0]};

  // After WRITE->IDLE the pipeline advances only at the end of the following
  // cycle, so the same AMO is still presented; 'done' blocks a second launch.
  assign start = (state == AMO_IDLE) & i_is_amo & ~i_flush & ~done & ~i_reset;

  amo_alu #(.XLEN(XLEN)) u_alu (
    .op(op_r), .old_val(i_data_mem_rd_data), .rs2(rs2_r), .new_val(new_val)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= AMO_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AMO_IDLE:  if (start) state_nxt = AMO_READ;
      AMO_READ:  state_nxt = i_flush ? AMO_IDLE : AMO_WRITE;
      AMO_WRITE: state_nxt = i_stall_other ? AMO_HOLD : AMO_IDLE;
      AMO_HOLD:  if (!i_stall_other) state_nxt = AMO_IDLE;
      default:   state_nxt = AMO_IDLE;
    endcase
  end

  always_comb begin
    o_stall_for_amo         = 1'b0;
    o_mem_addr_override     = 1'b0;
    o_mem_address           = '0;
    o_mem_write_data        = '0;
    o_mem_byte_write_enable = 4'h0;
    o_amo_write_enable      = 1'b0;
    case (state)
      AMO_IDLE: if (start) begin
        o_stall_for_amo     = 1'b1;
        o_mem_addr_override = 1'b1;
        o_mem_address       = {i_address[XLEN-1:2], 2'b00};
      end
      AMO_READ: begin
        o_stall_for_amo     = 1'b1;
        o_mem_addr_override = 1'b1;
        o_mem_address       = {addr_r[XLEN-1:2], 2'b00};
      end
      AMO_WRITE: begin
        o_stall_for_amo         = 1'b1;
        o_mem_addr_override     = 1'b1;
        o_mem_address           = {addr_r[XLEN-1:2], 2'b00};
        o_mem_write_data        = new_val;
        o_mem_byte_write_enable = 4'hF;
        o_amo_write_enable      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_r         <= AMO_SWAP;
      addr_r       <= '0;
      rs2_r        <= '0;
      o_amo_result <= '0;
      done         <= 1'b0;
    end else begin
      if (start) begin
        op_r   <= i_amo_op;
        addr_r <= i_address;
        rs2_r  <= i_rs2_data;
      end
      if (state == AMO_WRITE) o_amo_result <= i_data_mem_rd_data;
      if (state == AMO_WRITE && state_nxt == AMO_IDLE) done <= 1'b1;
      else if (!i_stall_other || i_flush)              done <= 1'b0;
    end
  end

  // Reservation tracking
  assign adv       = ~(o_stall_for_amo | i_stall_other);
  assign in_mmio   = (i_address >= MMIO_ADDR) && (i_address < MMIO_ADDR + MMIO_SIZE_BYTES);
  assign snoop_hit = i_store_snoop_valid & (i_store_snoop_addr[XLEN-1:2] == rsv.word_addr);
  assign amo_hit   = (state == AMO_WRITE) & (addr_r[XLEN-1:2] == rsv.word_addr);

  assign o_sc_success = i_is_sc & rsv.valid & (i_address[XLEN-1:2] == rsv.word_addr) & ~in_mmio;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsv <= '0;
    end else if (i_flush) begin
      rsv.valid <= 1'b0;
    end else if (i_is_lr && adv) begin
      // LR set outranks a same-cycle snoop clear
      rsv.valid     <= 1'b1;
      rsv.word_addr <= i_address[XLEN-1:2];
    end else if ((i_is_sc && adv) || snoop_hit || amo_hit) begin
      rsv.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amo_unit.sv
module tb_amo_unit;
  import riscv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall_other, i_flush, i_is_amo, i_is_lr, i_is_sc;
  amo_op_e     i_amo_op;
  logic [31:0] i_address, i_rs2_data, i_data_mem_rd_data, i_store_snoop_addr;
  logic        i_store_snoop_valid;
  logic        o_stall_for_amo, o_mem_addr_override, o_amo_write_enable, o_sc_success;
  logic [31:0] o_mem_address, o_mem_write_data, o_amo_result;
  logic [3:0]  o_mem_byte_write_enable;

  always #5 i_clk = ~i_clk;

  amo_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall_other(i_stall_other), .i_flush(i_flush),
    .i_is_amo(i_is_amo), .i_amo_op(i_amo_op), .i_is_lr(i_is_lr), .i_is_sc(i_is_sc),
    .i_address(i_address), .i_rs2_data(i_rs2_data), .i_data_mem_rd_data(i_data_mem_rd_data),
    .i_store_snoop_valid(i_store_snoop_valid), .i_store_snoop_addr(i_store_snoop_addr),
    .o_stall_for_amo(o_stall_for_amo), .o_mem_addr_override(o_mem_addr_override),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .o_mem_byte_write_enable(o_mem_byte_write_enable), .o_amo_result(o_amo_result),
    .o_amo_write_enable(o_amo_write_enable), .o_sc_success(o_sc_success)
  );

  // BRAM with 1-cycle read latency, read-before-write
  logic [31:0] mem [0:255];
  always @(posedge i_clk) begin
    i_data_mem_rd_data <= mem[o_mem_address[9:2]];
    if (o_mem_byte_write_enable == 4'hF) mem[o_mem_address[9:2]] <= o_mem_write_data;
  end

  int checks = 0, errors = 0, wr_cnt = 0, pulse_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory image and operation semantics
  logic [31:0] mem_ref [0:255];
  function automatic logic [31:0] amo_ref(amo_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      AMO_SWAP: return b;
      AMO_ADD:  return a + b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
`ifdef FROST_AMO_MINMAX_EN
      AMO_MIN:  return ($signed(a) <= $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) >= $signed(b)) ? a : b;
      AMO_MINU: return (a <= b) ? a : b;
      AMO_MAXU: return (a >= b) ? a : b;
`endif
      default:  return a;
    endcase
  endfunction

  typedef struct { logic [31:0] addr, old, nw; } exp_t;
  exp_t q[$];
  logic        res_pend = 1'b0;
  logic [31:0] res_old;

  // Compare process: every write pulse must match the next expected AMO
  always @(negedge i_clk) begin
    exp_t e;
    if (res_pend) begin
      chk("amo_result", o_amo_result, res_old);
      res_pend = 1'b0;
    end
    if (o_mem_byte_write_enable != 4'h0) wr_cnt++;
    if (o_amo_write_enable) begin
      pulse_cnt++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got pulse at addr %h expected none", o_mem_address);
      end else begin
        e = q.pop_front();
        chk("wr_addr", {2'b00, o_mem_address[31:2]}, {2'b00, e.addr[31:2]});
        chk("wr_data", o_mem_write_data, e.nw);
        chk("wr_be", {28'd0, o_mem_byte_write_enable}, 32'hF);
        res_old  = e.old;
        res_pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic amo_seq(amo_op_e op, logic [31:0] addr, logic [31:0] rs2,
                         int hold, bit flush_read, bit flush_write);
    logic [31:0] old, nw;
    int w0, p0;
    w0 = wr_cnt; p0 = pulse_cnt;
    old = mem_ref[addr[9:2]];
    nw  = amo_ref(op, old, rs2);
    if (!flush_read) begin
      q.push_back('{addr, old, nw});
      mem_ref[addr[9:2]] = nw;
    end
    i_is_amo = 1; i_amo_op = op; i_address = addr; i_rs2_data = rs2;
    @(negedge i_clk);
    chk("detect_stall", {31'd0, o_stall_for_amo}, 1);
    chk("detect_ovr", {31'd0, o_mem_addr_override}, 1);
    chk("detect_addr", o_mem_address, addr);
    tick();
    if (flush_read) i_flush = 1;
    @(negedge i_clk);
    chk("read_stall", {31'd0, o_stall_for_amo}, 1);
    chk("read_be", {28'd0, o_mem_byte_write_enable}, 0);
    tick();
    if (flush_read) begin
      i_flush = 0; i_is_amo = 0;
      @(negedge i_clk);
      chk("flush_stall_drop", {31'd0, o_stall_for_amo}, 0);
      tick(); tick();
      chk("flush_no_write", wr_cnt, w0);
      chk("flush_no_pulse", pulse_cnt, p0);
      return;
    end
    i_flush = flush_write; i_stall_other = (hold > 0);
    @(negedge i_clk);
    chk("write_stall", {31'd0, o_stall_for_amo}, 1);
    chk("write_be", {28'd0, o_mem_byte_write_enable}, 32'hF);
    tick();
    i_flush = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clk);
      chk("hold_stall", {31'd0, o_stall_for_amo}, 0);
      chk("hold_ovr", {31'd0, o_mem_addr_override}, 0);
      chk("hold_state", {30'd0, dut.state}, {30'd0, AMO_HOLD});
      tick();
    end
    i_stall_other = 0;
    @(negedge i_clk);
    chk("no_retrigger", {31'd0, o_stall_for_amo}, 0);
    tick();
    i_is_amo = 0;
    @(negedge i_clk);
    chk("state_idle", {30'd0, dut.state}, {30'd0, AMO_IDLE});
    chk("one_write", wr_cnt, w0 + 1);
    chk("one_pulse", pulse_cnt, p0 + 1);
    chk("mem_model", mem[addr[9:2]], nw);
    tick();
  endtask

  task automatic lr(logic [31:0] addr);
    i_is_lr = 1; i_address = addr; tick(); i_is_lr = 0;
  endtask

  task automatic sc(string name, logic [31:0] addr, logic exp);
    i_is_sc = 1; i_address = addr;
    @(negedge i_clk);
    chk(name, {31'd0, o_sc_success}, {31'd0, exp});
    tick(); i_is_sc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1; i_stall_other = 0; i_flush = 0; i_is_amo = 0; i_is_lr = 0; i_is_sc = 0;
    i_amo_op = AMO_SWAP; i_address = 0; i_rs2_data = 0;
    i_store_snoop_valid = 0; i_store_snoop_addr = 0;
    for (int i = 0; i < 256; i++) begin mem[i] <= i; mem_ref[i] = i; end
    mem[64] <= 32'd5;          mem_ref[64] = 32'd5;
    mem[65] <= 32'hFFFF_FFFF;  mem_ref[65] = 32'hFFFF_FFFF;
    mem[66] <= 32'hFFFF_FFFF;  mem_ref[66] = 32'hFFFF_FFFF;
    mem[67] <= 32'hFFFF_FFFF;  mem_ref[67] = 32'hFFFF_FFFF;
    mem[68] <= 32'hFFFF_FFFF;  mem_ref[68] = 32'hFFFF_FFFF;
    mem[69] <= 32'h0F0F_00FF;  mem_ref[69] = 32'h0F0F_00FF;
    mem[70] <= 32'h11;         mem_ref[70] = 32'h11;
    mem[72] <= 32'h7;          mem_ref[72] = 32'h7;
    repeat (3) tick();
    i_reset = 0;
    @(negedge i_clk);
    chk("rst_stall", {31'd0, o_stall_for_amo}, 0);
    chk("rst_ovr", {31'd0, o_mem_addr_override}, 0);
    chk("rst_be", {28'd0, o_mem_byte_write_enable}, 0);
    chk("rst_pulse", {31'd0, o_amo_write_enable}, 0);
    chk("rst_result", o_amo_result, 0);
    chk("rst_sc", {31'd0, o_sc_success}, 0);
    tick();

    amo_seq(AMO_ADD, 32'h100, 32'd3, 0, 0, 0);
    chk("add_mem_lit", mem[64], 32'd8);
    chk("add_res_lit", o_amo_result, 32'd5);
    amo_seq(AMO_MAXU, 32'h104, 32'd1, 0, 0, 0);
    chk("maxu_lit", mem[65], 32'hFFFF_FFFF);
    amo_seq(AMO_MIN, 32'h108, 32'd1, 0, 0, 0);
    chk("min_lit", mem[66], 32'hFFFF_FFFF);
    amo_seq(AMO_MINU, 32'h10C, 32'd1, 0, 0, 0);
`ifdef FROST_AMO_MINMAX_EN
    chk("minu_lit", mem[67], 32'd1);
`else
    chk("minu_lit", mem[67], 32'hFFFF_FFFF);
`endif
    amo_seq(AMO_MIN, 32'h120, 32'h8000_0000, 0, 0, 0);
`ifdef FROST_AMO_MINMAX_EN
    chk("min_neg_lit", mem[72], 32'h8000_0000);
`else
    chk("min_neg_lit", mem[72], 32'h7);
`endif
    amo_seq(AMO_MAX, 32'h100, 32'hFFFF_FFFF, 0, 0, 0);
    chk("max_lit", mem[64], 32'd8);
    amo_seq(AMO_ADD, 32'h110, 32'd2, 0, 0, 0);
    chk("add_wrap_lit", mem[68], 32'd1);
    amo_seq(AMO_XOR, 32'h114, 32'h0000_FFFF, 0, 0, 0);
    chk("xor_lit", mem[69], 32'h0F0F_FF00);
    amo_seq(AMO_AND, 32'h114, 32'hFF00_FF00, 0, 0, 0);
    chk("and_lit", mem[69], 32'h0F00_FF00);
    amo_seq(AMO_OR, 32'h114, 32'h0000_00FF, 0, 0, 0);
    chk("or_lit", mem[69], 32'h0F00_FFFF);
    amo_seq(AMO_SWAP, 32'h118, 32'hDEAD_BEEF, 4, 0, 0);
    chk("swap_lit", mem[70], 32'hDEAD_BEEF);
    chk("swap_res_lit", o_amo_result, 32'h11);

    // Reservation
    lr(32'h200);
    i_store_snoop_valid = 1; i_store_snoop_addr = 32'h202; tick(); i_store_snoop_valid = 0;
    sc("sc_after_snoop", 32'h200, 0);
    lr(32'h200);
    sc("sc_ok", 32'h200, 1);
    sc("sc_cleared", 32'h200, 0);
    lr(32'h200);
    sc("sc_other_addr", 32'h204, 0);
    lr(32'h200);
    i_is_lr = 1; i_address = 32'h200;
    i_store_snoop_valid = 1; i_store_snoop_addr = 32'h200; tick();
    i_is_lr = 0; i_store_snoop_valid = 0;
    sc("lr_beats_snoop", 32'h200, 1);
    lr(32'h4000_0000);
    sc("sc_mmio", 32'h4000_0000, 0);
    lr(32'h100);
    amo_seq(AMO_ADD, 32'h100, 32'd0, 0, 0, 0);
    sc("sc_after_amo", 32'h100, 0);
    lr(32'h200);
    i_flush = 1; tick(); i_flush = 0;
    sc("sc_after_flush", 32'h200, 0);

    // Flush
    amo_seq(AMO_ADD, 32'h100, 32'd1, 0, 1, 0);
    chk("flush_read_mem", mem[64], 32'd8);
    amo_seq(AMO_ADD, 32'h100, 32'd1, 0, 0, 1);
    chk("flush_write_mem", mem[64], 32'd9);

    // Reset in READ
    lr(32'h300);
    i_is_amo = 1; i_amo_op = AMO_ADD; i_address = 32'h300; i_rs2_data = 32'd1;
    tick();
    chk("pre_rst_state", {30'd0, dut.state}, {30'd0, AMO_READ});
    #1 i_reset = 1;
    #1;
    chk("midrst_stall", {31'd0, o_stall_for_amo}, 0);
    chk("midrst_ovr", {31'd0, o_mem_addr_override}, 0);
    chk("midrst_be", {28'd0, o_mem_byte_write_enable}, 0);
    chk("midrst_pulse", {31'd0, o_amo_write_enable}, 0);
    chk("midrst_result", o_amo_result, 0);
    chk("midrst_state", {30'd0, dut.state}, {30'd0, AMO_IDLE});
    chk("midrst_rsv", {31'd0, dut.rsv.valid}, 0);
    i_is_amo = 0;
    tick();
    i_reset = 0;
    tick();
    sc("sc_after_reset", 32'h300, 0);

    repeat (2) tick();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amo_unit.md
Name: amo_unit

Overview:
- Executes RV32A read-modify-write atomics (AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.W) and tracks the LR/SC reservation.
- Sits beside the EX→MA boundary. It samples the EX→MA register contents, takes over the data-memory port for a read followed by a write, and feeds the old value to the MA stage as the AMO result with its write-enable pulse.
- Stalls the pipeline for the duration of the sequence.

Parameters:
- XLEN, 32, data/address width.
- MMIO_ADDR, 32'h4000_0000, MMIO base. AMO/LR/SC into MMIO is not supported; the reservation never matches there.
- MMIO_SIZE_BYTES, 32'h28, MMIO window size.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_stall_other  in  1  stall from any source other than this block
- i_flush  in  1  pipeline flush (trap/redirect)
- i_is_amo  in  1  EX→MA holds an AMO
- i_amo_op  in  4  riscv_pkg::amo_op_e encoding
- i_is_lr  in  1  EX→MA holds LR.W
- i_is_sc  in  1  EX→MA holds SC.W
- i_address  in  XLEN  word address (bits[1:0] ignored)
- i_rs2_data  in  XLEN  AMO operand
- i_data_mem_rd_data  in  XLEN  BRAM read data, 1-cycle latency
- i_store_snoop_valid  in  1  a committed regular store is writing memory this cycle
- i_store_snoop_addr  in  XLEN  address of that store
- o_stall_for_amo  out  1  pipeline stall request
- o_mem_addr_override  out  1  this block drives the memory address
- o_mem_address  out  XLEN  override address
- o_mem_write_data  out  XLEN  write data
- o_mem_byte_write_enable  out  4  byte enables
- o_amo_result  out  XLEN  old memory value (rd)
- o_amo_write_enable  out  1  one-cycle pulse: o_amo_result valid
- o_sc_success  out  1  combinational SC outcome

Behaviour:
- States (riscv_pkg::amo_state_e): IDLE, READ, WRITE, HOLD.
- Reset: state=IDLE, reservation invalid, o_amo_result=0. All outputs 0 except o_amo_result, which is registered.
- IDLE:
  - If i_is_amo & ~i_flush: o_stall_for_amo=1 combinationally, override=1, address=i_address, go to READ.
  - Otherwise idle.
- READ:
  - Stall=1, override=1, address held (registered copy).
  - BRAM data appears at the next edge. Go to WRITE.
- WRITE:
  - old = i_data_mem_rd_data; new = amo_alu(op, old, rs2_reg).
  - Drive byte_we=4'hF and write_data=new.
  - o_amo_write_enable=1 this cycle only; o_amo_result<=old at the edge.
  - Stall=1 this cycle; it drops the next cycle.
  - Go to HOLD if i_stall_other, else IDLE.
- HOLD:
  - No stall, no override. Waits for ~i_stall_other, then goes to IDLE.
  - This prevents retriggering on the same EX→MA contents while another stall freezes the pipeline.
- Latency: the AMO occupies 3 cycles of stall (detect, READ, WRITE). The result pulse comes in the 3rd cycle.
- Operands: captured into registers at IDLE→READ (op, address, rs2).
- Arithmetic:
  - ADD wraps modulo 2^XLEN.
  - MIN/MAX are signed; MINU/MAXU are unsigned.
  - SWAP writes rs2.
- Flush:
  - In IDLE or READ: abort to IDLE with no write and no result pulse.
  - In WRITE: ignored; the write and the pulse complete, so atomicity holds.
  - Flush always invalidates the reservation.
- Reservation:
  - Set {valid, addr[XLEN-1:2]} when i_is_lr and the pipeline advances (~stall).
  - o_sc_success = i_is_sc & valid & addr match & ~MMIO.
  - Any SC invalidates the reservation when it advances.
  - A store snoop or AMO WRITE to the matching word invalidates it.
  - Simultaneous LR set and snoop clear: the LR set wins.
- Reset asserted mid-sequence: immediate return to IDLE. The memory write is not guaranteed.

Optional Feature:
- FROST_AMO_MINMAX_EN defined: MIN/MAX/MINU/MAXU computed as specified.
- Undefined: the min/max comparators are not built. Those encodings write the old value back unchanged (memory unmodified), and rd still receives the old value.

Decomposition:
- riscv_pkg holds: amo_op_e (SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU), amo_state_e, and the reservation struct {valid, word_addr}.
- Sub-module amo_alu: purely combinational (op, old, rs2) → new. Contains the min/max logic under the macro.

Test Plan:
- Memory[0x100]=5, AMOADD rs2=3 → stall high for 3 cycles; o_amo_result=5 with the pulse; mem[0x100]=8; no retrigger.
- AMOMAXU on 0xFFFF_FFFF vs rs2=1 → mem unchanged 0xFFFF_FFFF. AMOMIN on 0xFFFF_FFFF vs 1 → mem 0xFFFF_FFFF (signed -1). Without the macro, both leave mem unchanged.
- AMOSWAP with i_stall_other held 4 cycles after WRITE → exactly one write and one pulse; the FSM sits in HOLD, then IDLE.
- LR 0x200, then store snoop 0x202 → subsequent SC to 0x200 gives o_sc_success=0. Repeat without the snoop → o_sc_success=1, then the reservation clears.
- Flush during READ → no byte_we, no pulse, stall drops the next cycle. Flush during WRITE → the write completes.
- i_reset asserted in READ → outputs 0 asynchronously, state IDLE, reservation invalid.
